// File: rtl/seq_int_div_if.sv
// seq_int_div_if: operand/result handshake bundle for the sequential divider.
//   in_valid/in_ready     : operand handshake (dividend, divisor, is_signed)
//   out_valid/out_ready   : result handshake (quotient, remainder, div_by_zero)
// master = producer of operands / consumer of results; slave = the divider.
interface seq_int_div_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_int_div.sv
// seq_int_div: multi-cycle restoring integer divider, signed or unsigned per op.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : seq_int_div_if.slave -- operand handshake in, result handshake out
// One restoring step per cycle. Flow: IDLE -> PREP -> ITER (WIDTH cycles) ->
// FIX -> DONE, or IDLE -> PREP -> DONE when the divisor is zero.
// Results follow Verilog / and %: quotient truncates toward zero, remainder
// carries the dividend's sign; MIN / -1 wraps to MIN with remainder 0.
module seq_int_div #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_int_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_in, b_in;     // operands as captured at accept
  logic             sgn;
  logic [WIDTH-1:0] dvd;            // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dsr;            // divisor magnitude
  logic [WIDTH-1:0] rem;            // partial remainder
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] quo_q, rmd_q;
  logic             dbz_q, out_valid_q;

  // Shifted partial remainder needs one extra bit; the trial difference is
  // negative exactly when its top bit is set.
  logic [WIDTH:0] rem_sh, trial;
  assign rem_sh = {rem, dvd[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_in        <= '0;
      b_in        <= '0;
      sgn         <= 1'b0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quo_q       <= '0;
      rmd_q       <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_in  <= bus.dividend;
            b_in  <= bus.divisor;
            sgn   <= bus.is_signed;
            state <= PREP;
          end
        end
        PREP: begin
          dvd   <= mag(a_in, sgn);
          dsr   <= mag(b_in, sgn);
          neg_q <= sgn && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          neg_r <= sgn && a_in[WIDTH-1];
          rem   <= '0;
          cnt   <= '0;
          if (b_in == '0) begin
            // Zero divisor bypasses iteration; remainder reports the raw dividend.
            quo_q       <= '1;
            rmd_q       <= a_in;
            dbz_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          // Quotient bits shift into the vacated low end of dvd.
          dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
          rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          quo_q       <= neg_q ? -dvd : dvd;
          rmd_q       <= neg_r ? -rem : rem;
          dbz_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_int_div.sv
// tb_seq_int_div: scoreboard bench for seq_int_div at WIDTH=8 (directed) and
// WIDTH=16 (randomised against / and %). Issue tasks push expected results;
// per-instance monitors pop and compare on each output handshake.
module tb_seq_int_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_int_div_if #(.WIDTH(8))  b8();
  seq_int_div_if #(.WIDTH(16)) b16();

  seq_int_div #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  seq_int_div #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    string       nm;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: compare on every accepted result.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8 unexpected result: got q=%0h r=%0h, expected none", b8.quotient, b8.remainder);
      end else begin
        e = q8.pop_front();
        chk({e.nm, " q"},   b8.quotient,    e.q[7:0]);
        chk({e.nm, " r"},   b8.remainder,   e.r[7:0]);
        chk({e.nm, " dbz"}, b8.div_by_zero, e.dbz);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL w16 unexpected result: got q=%0h r=%0h, expected none", b16.quotient, b16.remainder);
      end else begin
        e = q16.pop_front();
        chk({e.nm, " q"},   b16.quotient,    e.q);
        chk({e.nm, " r"},   b16.remainder,   e.r);
        chk({e.nm, " dbz"}, b16.div_by_zero, e.dbz);
      end
    end
  end

  // Called at posedge+1; waits for in_ready, presents one op for one cycle.
  task automatic issue(input bit w, input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] eq, input logic [15:0] er,
                       input logic ed, input bit push);
    int n = 0;
    exp_t e;
    while (!(w ? b16.in_ready : b8.in_ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " accept in time"}, (n < 200), 1);
    if (w) begin
      b16.dividend = a; b16.divisor = b; b16.is_signed = s; b16.in_valid = 1'b1;
    end else begin
      b8.dividend = a[7:0]; b8.divisor = b[7:0]; b8.is_signed = s; b8.in_valid = 1'b1;
    end
    if (push) begin
      e.q = eq; e.r = er; e.dbz = ed; e.nm = nm;
      if (w) q16.push_back(e); else q8.push_back(e);
    end
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    b16.in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic wait_out8(output int lat);
    lat = 0;
    while (!b8.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] a, b, eq, er;
    logic signed [15:0] sa, sb;
    logic s, ed;

    b8.in_valid = 0; b8.dividend = 0; b8.divisor = 0; b8.is_signed = 0; b8.out_ready = 1;
    b16.in_valid = 0; b16.dividend = 0; b16.divisor = 0; b16.is_signed = 0; b16.out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready",  b8.in_ready,    1);
    chk("rst out_valid", b8.out_valid,   0);
    chk("rst q",         b8.quotient,    0);
    chk("rst r",         b8.remainder,   0);
    chk("rst dbz",       b8.div_by_zero, 0);
    chk("rst16 in_ready", b16.in_ready,  1);
    chk("rst16 out_valid", b16.out_valid, 0);
    rst_n = 1'b1;

    // Unsigned
    issue(0, "u 10/4", 10, 4, 0, 2, 2, 0, 1);
    wait_out8(lat);
    chk("u 10/4 latency", lat, 10);
    issue(0, "u 255/1", 255, 1, 0, 8'hFF, 0, 0, 1);
    issue(0, "u 200/7", 200, 7, 0, 28, 4, 0, 1);

    // Signed
    issue(0, "s 10/4",   10,    4,     1, 2,     2,     0, 1);
    issue(0, "s -10/4",  8'hF6, 4,     1, 8'hFE, 8'hFE, 0, 1);
    issue(0, "s 10/-4",  10,    8'hFC, 1, 8'hFE, 2,     0, 1);
    issue(0, "s -10/-4", 8'hF6, 8'hFC, 1, 2,     8'hFE, 0, 1);
    issue(0, "s -128/-1", 8'h80, 8'hFF, 1, 8'h80, 0,    0, 1);

    // Divide by zero: out_valid rises at the PREP edge right after the accept edge.
    issue(0, "u 37/0", 37, 0, 0, 8'hFF, 37, 1, 1);
    wait_out8(lat);
    chk("div0 latency", lat, 1);
    issue(0, "u 9/3", 9, 3, 0, 3, 0, 0, 1);

    // Backpressure with an ignored in_valid pulse.
    issue(0, "bp 50/5", 50, 5, 0, 10, 0, 0, 1);
    b8.out_ready = 0;
    wait_out8(lat);
    chk("bp latency", lat, 10);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", b8.out_valid, 1);
      chk("bp in_ready",  b8.in_ready,  0);
      chk("bp q hold",    b8.quotient,  10);
      chk("bp r hold",    b8.remainder, 0);
      if (i == 2) begin
        b8.dividend = 1; b8.divisor = 1; b8.is_signed = 0; b8.in_valid = 1;
      end else begin
        b8.in_valid = 0;
      end
      @(posedge clk); #1;
    end
    b8.in_valid = 0;
    b8.out_ready = 1;
    issue(0, "u 20/6", 20, 6, 0, 3, 2, 0, 1);

    // Reset in the 4th ITER cycle: no result for the aborted op.
    issue(0, "abort 77/3", 77, 3, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort in_ready",  b8.in_ready,    1);
    chk("abort out_valid", b8.out_valid,   0);
    chk("abort q",         b8.quotient,    0);
    chk("abort r",         b8.remainder,   0);
    chk("abort dbz",       b8.div_by_zero, 0);
    rst_n = 1'b1;
    issue(0, "u 100/9", 100, 9, 0, 11, 1, 0, 1);
    wait_out8(lat);
    chk("post-reset latency", lat, 10);

    // Randomised WIDTH=16
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      case (i % 8)
        0: b = 16'h0000;
        1: b = 16'($urandom_range(1, 15));
        2: begin a = 16'h8000; b = 16'hFFFF; end
        default: ;
      endcase
      sa = a; sb = b; ed = 0;
      if (b == 0) begin
        eq = 16'hFFFF; er = a; ed = 1;
      end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
        eq = 16'h8000; er = 0;
      end else if (s) begin
        eq = sa / sb; er = sa % sb;
      end else begin
        eq = a / b; er = a % b;
      end
      issue(1, "rnd16", a, b, s, eq, er, ed, 1);
    end

    lat = 0;
    while ((q8.size() != 0 || q16.size() != 0) && lat < 500) begin
      @(posedge clk); #1; lat++;
    end
    chk("scoreboard drained", q8.size() + q16.size(), 0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
